// File: rtl/gem_ext_fifo_rx.sv
// gem_ext_fifo_rx
//   Receive-side GEM external FIFO bridge. Takes the byte-write stream the GEM
//   MAC drives on its external Rx FIFO interface and replays it as an
//   AXI4-Stream master frame. A small data FIFO absorbs sink backpressure.
//   When the FIFO fills mid-frame, the frame is truncated with an error mark
//   and the rest of it is dropped. Also echoes the GEM DMA Rx status toggle.
//
//   Ports
//     clk, rst              clock, asynchronous active-high reset
//     gem_rx_w_*            MAC write side: data/wr/sop/eop/err/flush/status,
//                           overflow back to the MAC
//     gem_dma_rx_end_tog    per-frame toggle from MAC
//     gem_dma_rx_status_tog echoed toggle to MAC
//     m_axis_*              AXI4-Stream master (tdata/tvalid/tready/tlast/tuser)
//     drop_cnt              saturating count of truncated frames
//
//   Optional feature, macro GEM_EXT_FIFO_RX_STATUS_EN:
//     adds rx_status[44:0] and rx_status_valid; the status word is captured on
//     every accepted eop and rx_status_valid pulses for one cycle.
//
//   FIFO_DEPTH counts the output stage as well as the memory, so at most
//   FIFO_DEPTH bytes are ever buffered; the last slot is kept for a frame
//   terminator.
module gem_ext_fifo_rx #(
  parameter int FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  gem_rx_w_data,
  input  logic        gem_rx_w_wr,
  input  logic        gem_rx_w_sop,
  input  logic        gem_rx_w_eop,
  input  logic        gem_rx_w_err,
  input  logic        gem_rx_w_flush,
  input  logic [44:0] gem_rx_w_status,
  output logic        gem_rx_w_overflow,
  input  logic        gem_dma_rx_end_tog,
  output logic        gem_dma_rx_status_tog,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
`ifdef GEM_EXT_FIFO_RX_STATUS_EN
  output logic [44:0] rx_status,
  output logic        rx_status_valid,
`endif
  output logic [15:0] drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW+1:0] OCC_LIM = (AW+2)'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FRAME = 2'd1, S_DROP = 2'd2} state_t;

  state_t        state, state_n;
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, mem_cnt;
  logic [AW+1:0] occ;
  logic          mem_empty, mem_full, load_out;
  logic [7:0]    hold_p0;
  logic          push_req, push_en, hold_load, drop_inc, ovf_set, ovf_clr, eop_acc;
  logic [9:0]    push_entry;
  logic          end_tog_p0, end_tog_p1;

  assign mem_cnt   = wr_ptr - rd_ptr;
  // Occupancy includes the byte parked in the output register.
  assign occ       = {1'b0, mem_cnt} + (AW+2)'(m_axis_tvalid);
  assign mem_empty = (mem_cnt == '0);
  assign mem_full  = mem_cnt[AW];
  assign load_out  = !mem_empty && (!m_axis_tvalid || m_axis_tready);
  // Only reachable after a back-to-back terminator; the new frame has not
  // pushed anything yet, so suppressing the write loses no partial frame.
  assign push_en   = push_req && !mem_full;

  // Write-side FSM: next state and push decisions
  always_comb begin
    state_n    = state;
    push_req   = 1'b0;
    push_entry = '0;
    hold_load  = 1'b0;
    drop_inc   = 1'b0;
    ovf_set    = 1'b0;
    ovf_clr    = 1'b0;
    eop_acc    = 1'b0;
    if (gem_rx_w_flush) begin
      state_n = S_IDLE;
      ovf_clr = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (gem_rx_w_wr && gem_rx_w_sop) begin
            hold_load = 1'b1;
            state_n   = S_FRAME;
          end
        end
        S_FRAME: begin
          if (gem_rx_w_eop) begin
            push_req   = 1'b1;
            push_entry = {hold_p0, 1'b1, gem_rx_w_err};
            eop_acc    = 1'b1;
            state_n    = S_IDLE;
          end else if (gem_rx_w_wr && gem_rx_w_sop) begin
            // Missing eop: close the old frame as bad, start the new one.
            push_req   = 1'b1;
            push_entry = {hold_p0, 1'b1, 1'b1};
            hold_load  = 1'b1;
          end else if (gem_rx_w_wr) begin
            push_req = 1'b1;
            if (occ < OCC_LIM) begin
              push_entry = {hold_p0, 1'b0, 1'b0};
              hold_load  = 1'b1;
            end else begin
              push_entry = {hold_p0, 1'b1, 1'b1};
              drop_inc   = 1'b1;
              ovf_set    = 1'b1;
              state_n    = S_DROP;
            end
          end
        end
        S_DROP: begin
          if (gem_rx_w_eop) begin
            ovf_clr = 1'b1;
            eop_acc = 1'b1;
            state_n = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Stage p0: hold register and FIFO memory write
  always_ff @(posedge clk) begin
    if (hold_load) hold_p0 <= gem_rx_w_data;
    if (push_en)   mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  // Stage p1: pointers, registered read stage, overflow and drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      m_axis_tvalid     <= 1'b0;
      m_axis_tdata      <= '0;
      m_axis_tlast      <= 1'b0;
      m_axis_tuser      <= 1'b0;
      gem_rx_w_overflow <= 1'b0;
      drop_cnt          <= '0;
    end else begin
      if (gem_rx_w_flush) begin
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        m_axis_tvalid <= 1'b0;
      end else begin
        if (push_en) wr_ptr <= wr_ptr + (AW+1)'(1);
        if (load_out) begin
          rd_ptr <= rd_ptr + (AW+1)'(1);
          {m_axis_tdata, m_axis_tlast, m_axis_tuser} <= mem[rd_ptr[AW-1:0]];
          m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
          m_axis_tvalid <= 1'b0;
        end
      end
      if (ovf_clr)      gem_rx_w_overflow <= 1'b0;
      else if (ovf_set) gem_rx_w_overflow <= 1'b1;
      if (drop_inc && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // DMA status toggle: sync copy, then compare against the previous copy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      end_tog_p0            <= 1'b0;
      end_tog_p1            <= 1'b0;
      gem_dma_rx_status_tog <= 1'b0;
    end else begin
      end_tog_p0 <= gem_dma_rx_end_tog;
      end_tog_p1 <= end_tog_p0;
      if (end_tog_p0 != end_tog_p1) gem_dma_rx_status_tog <= ~gem_dma_rx_status_tog;
    end
  end

`ifdef GEM_EXT_FIFO_RX_STATUS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_status       <= '0;
      rx_status_valid <= 1'b0;
    end else begin
      rx_status_valid <= eop_acc;
      if (eop_acc) rx_status <= gem_rx_w_status;
    end
  end
`else
  logic unused_status;
  assign unused_status = ^{gem_rx_w_status, eop_acc};
`endif

endmodule

// File: tb/tb_gem_ext_fifo_rx.sv
// Directed bench for gem_ext_fifo_rx (FIFO_DEPTH = 16).
module tb_gem_ext_fifo_rx;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  gem_rx_w_data = '0;
  logic        gem_rx_w_wr = 1'b0;
  logic        gem_rx_w_sop = 1'b0;
  logic        gem_rx_w_eop = 1'b0;
  logic        gem_rx_w_err = 1'b0;
  logic        gem_rx_w_flush = 1'b0;
  logic [44:0] gem_rx_w_status = '0;
  logic        gem_rx_w_overflow;
  logic        gem_dma_rx_end_tog = 1'b0;
  logic        gem_dma_rx_status_tog;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic [15:0] drop_cnt;
`ifdef GEM_EXT_FIFO_RX_STATUS_EN
  logic [44:0] rx_status;
  logic        rx_status_valid;
`endif

  int checks = 0;
  int errors = 0;
  logic [9:0] beats [$];
  logic exp_tog = 1'b0;

  gem_ext_fifo_rx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .gem_rx_w_data         (gem_rx_w_data),
    .gem_rx_w_wr           (gem_rx_w_wr),
    .gem_rx_w_sop          (gem_rx_w_sop),
    .gem_rx_w_eop          (gem_rx_w_eop),
    .gem_rx_w_err          (gem_rx_w_err),
    .gem_rx_w_flush        (gem_rx_w_flush),
    .gem_rx_w_status       (gem_rx_w_status),
    .gem_rx_w_overflow     (gem_rx_w_overflow),
    .gem_dma_rx_end_tog    (gem_dma_rx_end_tog),
    .gem_dma_rx_status_tog (gem_dma_rx_status_tog),
    .m_axis_tdata          (m_axis_tdata),
    .m_axis_tvalid         (m_axis_tvalid),
    .m_axis_tready         (m_axis_tready),
    .m_axis_tlast          (m_axis_tlast),
    .m_axis_tuser          (m_axis_tuser),
`ifdef GEM_EXT_FIFO_RX_STATUS_EN
    .rx_status             (rx_status),
    .rx_status_valid       (rx_status_valid),
`endif
    .drop_cnt              (drop_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge, so at the falling edge
  // the handshake for the next rising edge is settled.
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready)
      beats.push_back({m_axis_tdata, m_axis_tlast, m_axis_tuser});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic sop);
    gem_rx_w_data = d;
    gem_rx_w_wr   = 1'b1;
    gem_rx_w_sop  = sop;
    tick();
    gem_rx_w_wr   = 1'b0;
    gem_rx_w_sop  = 1'b0;
  endtask

  task automatic send_eop(input logic err);
    gem_rx_w_eop = 1'b1;
    gem_rx_w_err = err;
    tick();
    gem_rx_w_eop = 1'b0;
    gem_rx_w_err = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] first, input int len, input logic err);
    for (int i = 0; i < len; i++) send_byte(first + 8'(i), (i == 0));
    send_eop(err);
  endtask

  // Pops len beats from the front of the capture queue and compares each
  // against {first+i, last-only-on-final, err-only-on-final}.
  task automatic check_frame(input string tag, input logic [7:0] first, input int len,
                             input logic err);
    logic [9:0] e;
    logic       lst;
    chk({tag, "_avail"}, (beats.size() >= len) ? 64'd1 : 64'd0, 64'd1);
    for (int i = 0; i < len; i++) begin
      if (beats.size() > 0) begin
        lst = (i == len - 1);
        e   = {first + 8'(i), lst, lst & err};
        chk(tag, beats.pop_front(), e);
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tuser", m_axis_tuser, 0);
    chk("rst_overflow", gem_rx_w_overflow, 0);
    chk("rst_status_tog", gem_dma_rx_status_tog, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    tick();

    // 64-byte clean frame, sink always ready
    m_axis_tready = 1'b1;
    send_frame(8'h01, 64, 1'b0);
    repeat (6) tick();
    check_frame("frame64", 8'h01, 64, 1'b0);
    chk("frame64_rest", beats.size(), 0);
    chk("frame64_drop", drop_cnt, 0);

    // Same frame, MAC reports it bad
    send_frame(8'h01, 64, 1'b1);
    repeat (6) tick();
    check_frame("frame64_err", 8'h01, 64, 1'b1);
    chk("frame64_err_rest", beats.size(), 0);

    // Overflow: sink stalled, 40-byte frame into a 16-deep buffer.
    // Writes 2..16 push bytes 1..15; write 17 finds 15 occupied and closes
    // the frame with byte 16 marked last+err.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 17; i++) send_byte(8'(i + 1), (i == 0));
    chk("ovf_rise", gem_rx_w_overflow, 1);
    chk("ovf_drop_cnt", drop_cnt, 1);
    for (int i = 17; i < 40; i++) send_byte(8'(i + 1), 1'b0);
    chk("ovf_held", gem_rx_w_overflow, 1);
    chk("ovf_tvalid", m_axis_tvalid, 1);
    send_eop(1'b0);
    chk("ovf_fall", gem_rx_w_overflow, 0);
    m_axis_tready = 1'b1;
    repeat (24) tick();
    check_frame("ovf_frame", 8'h01, 16, 1'b1);
    chk("ovf_rest", beats.size(), 0);
    chk("ovf_drop_after", drop_cnt, 1);
    send_frame(8'hA0, 8, 1'b0);
    repeat (6) tick();
    check_frame("after_ovf", 8'hA0, 8, 1'b0);
    chk("after_ovf_rest", beats.size(), 0);

    // Second sop after 5 bytes without eop
    for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i), (i == 0));
    send_frame(8'h20, 6, 1'b0);
    repeat (6) tick();
    check_frame("noeop_a", 8'h10, 5, 1'b1);
    check_frame("noeop_b", 8'h20, 6, 1'b0);
    chk("noeop_rest", beats.size(), 0);
    chk("noeop_drop", drop_cnt, 1);

    // Flush with sink stalled
    m_axis_tready = 1'b0;
    for (int i = 0; i < 10; i++) send_byte(8'h30 + 8'(i), (i == 0));
    chk("flush_pre_tvalid", m_axis_tvalid, 1);
    gem_rx_w_flush = 1'b1;
    tick();
    gem_rx_w_flush = 1'b0;
    chk("flush_tvalid", m_axis_tvalid, 0);
    m_axis_tready = 1'b1;
    repeat (3) tick();
    chk("flush_no_leak", beats.size(), 0);
    send_frame(8'h50, 4, 1'b0);
    repeat (6) tick();
    check_frame("post_flush", 8'h50, 4, 1'b0);
    chk("post_flush_rest", beats.size(), 0);

    // Asynchronous reset mid-frame
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(8'h60 + 8'(i), (i == 0));
    chk("areset_pre_tvalid", m_axis_tvalid, 1);
    rst = 1'b1;
    #2;
    chk("areset_tvalid", m_axis_tvalid, 0);
    chk("areset_drop", drop_cnt, 0);
    #2;
    rst = 1'b0;
    tick();
    m_axis_tready = 1'b1;
    send_frame(8'h70, 3, 1'b0);
    repeat (6) tick();
    check_frame("post_areset", 8'h70, 3, 1'b0);
    chk("post_areset_rest", beats.size(), 0);

    // Status toggle echo, two edges after each end_tog change
    for (int k = 0; k < 3; k++) begin
      gem_dma_rx_end_tog = ~gem_dma_rx_end_tog;
      tick();
      chk("tog_hold", gem_dma_rx_status_tog, exp_tog);
      exp_tog = ~exp_tog;
      tick();
      chk("tog_flip", gem_dma_rx_status_tog, exp_tog);
      repeat (2) tick();
    end

`ifdef GEM_EXT_FIFO_RX_STATUS_EN
    gem_rx_w_status = 45'h1ABCD;
    send_byte(8'h80, 1'b1);
    send_eop(1'b0);
    gem_rx_w_status = '0;
    chk("status_valid", rx_status_valid, 1);
    chk("status_word", rx_status, 45'h1ABCD);
    tick();
    chk("status_valid_pulse", rx_status_valid, 0);
    chk("status_word_held", rx_status, 45'h1ABCD);
    repeat (4) tick();
    check_frame("status_frame", 8'h80, 1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
